// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues one op to the combinational ALU, holds it, captures ZHI/ZLO.
// Optional illegal-op trap pulse on err enabled by ALU_SEQ_ILLEGAL_TRAP_EN.
module alu_op_sequencer #(
  parameter int BITS          = 32,
  parameter int SIMPLE_CYCLES = 1,
  parameter int MULDIV_CYCLES = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [BITS-1:0]   req_x,
  input  logic [BITS-1:0]   req_y,
  output logic [11:0]       ctrl_signal,
  output logic [BITS-1:0]   alu_x,
  output logic [BITS-1:0]   alu_y,
  input  logic [2*BITS-1:0] alu_result,
  output logic [BITS-1:0]   zhi,
  output logic [BITS-1:0]   zlo,
  output logic              done,
  output logic              busy,
  output logic              err
);

  localparam int MAXL = (SIMPLE_CYCLES > MULDIV_CYCLES) ?
                        SIMPLE_CYCLES : MULDIV_CYCLES;
  localparam int CW   = $clog2(MAXL + 1);

  localparam logic [CW-1:0] SIMPLE_LD = CW'(SIMPLE_CYCLES - 1);
  localparam logic [CW-1:0] MULDIV_LD = CW'(MULDIV_CYCLES - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [11:0]     ctrl_q, ctrl_d;
  logic [BITS-1:0] x_q, x_d;
  logic [BITS-1:0] y_q, y_d;
  logic [BITS-1:0] zhi_q, zhi_d;
  logic [BITS-1:0] zlo_q, zlo_d;
  logic            done_q, done_d;

  logic accept;
  logic legal;
  logic req_md;
  logic cur_md;

  assign req_ready = (state_q == IDLE) && clr;
  assign accept    = req_valid && req_ready;
  assign legal     = req_op < 4'd12;
  assign req_md    = (req_op == 4'd2) || (req_op == 4'd3);
  assign cur_md    = ctrl_q[2] | ctrl_q[3];

  // Next-state: issue on accept, count down the hold, capture on expiry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    x_d     = x_q;
    y_d     = y_q;
    zhi_d   = zhi_q;
    zlo_d   = zlo_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept && legal) begin
          x_d     = req_x;
          y_d     = req_y;
          ctrl_d  = 12'b1 << req_op;
          cnt_d   = req_md ? MULDIV_LD : SIMPLE_LD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          if (cur_md) begin
            {zhi_d, zlo_d} = alu_result;
          end else begin
            zhi_d = '0;
            zlo_d = alu_result[BITS-1:0];
          end
          ctrl_d  = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by clr.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ctrl_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      zhi_q   <= '0;
      zlo_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      x_q     <= x_d;
      y_q     <= y_d;
      zhi_q   <= zhi_d;
      zlo_q   <= zlo_d;
      done_q  <= done_d;
    end
  end

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  logic err_q;

  // Illegal op is swallowed in IDLE and flagged one cycle later.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) err_q <= 1'b0;
    else      err_q <= accept && !legal;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign ctrl_signal = ctrl_q;
  assign alu_x       = x_q;
  assign alu_y       = y_q;
  assign zhi         = zhi_q;
  assign zlo         = zlo_q;
  assign done        = done_q;
  assign busy        = (state_q == WAIT);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed + random ops against a behavioural ALU/sequencer model.
// Combinational ALU stub answers whatever ctrl_signal/alu_x/alu_y currently select.
module tb_alu_op_sequencer;

  localparam int BITS = 32;
  localparam int SC   = 1;
  localparam int MC   = 4;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              clr = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [3:0]        req_op = '0;
  logic [BITS-1:0]   req_x = '0;
  logic [BITS-1:0]   req_y = '0;
  logic [11:0]       ctrl_signal;
  logic [BITS-1:0]   alu_x;
  logic [BITS-1:0]   alu_y;
  logic [2*BITS-1:0] alu_result;
  logic [BITS-1:0]   zhi;
  logic [BITS-1:0]   zlo;
  logic              done;
  logic              busy;
  logic              err;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(
    .BITS(BITS), .SIMPLE_CYCLES(SC), .MULDIV_CYCLES(MC)
  ) dut (
    .clk(clk), .clr(clr),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_x(req_x), .req_y(req_y),
    .ctrl_signal(ctrl_signal), .alu_x(alu_x), .alu_y(alu_y),
    .alu_result(alu_result), .zhi(zhi), .zlo(zlo),
    .done(done), .busy(busy), .err(err)
  );

  function automatic logic [63:0] alu_fn(int op, logic [31:0] x, logic [31:0] y);
    logic [63:0] r;
    int s;
    s = int'(y[4:0]);
    r = {32'hDEAD_BEEF, 32'h0};
    case (op)
      0:  r[31:0] = x + y;
      1:  r[31:0] = x - y;
      2:  r = {32'h0, x} * {32'h0, y};
      3:  r = (y == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {x % y, x / y};
      4:  r[31:0] = x >> s;
      5:  r[31:0] = x << s;
      6:  r[31:0] = (x >> s) | (x << (32 - s));
      7:  r[31:0] = (x << s) | (x >> (32 - s));
      8:  r[31:0] = x & y;
      9:  r[31:0] = x | y;
      10: r[31:0] = -x;
      11: r[31:0] = ~x;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] exp_z(int op, logic [31:0] x, logic [31:0] y);
    logic [63:0] f;
    f = alu_fn(op, x, y);
    if (op == 2 || op == 3) return f;
    return {32'h0, f[31:0]};
  endfunction

  function automatic int exp_lat(int op);
    return (op == 2 || op == 3) ? MC : SC;
  endfunction

  // Combinational ALU: result of whichever op ctrl_signal selects, 0 when idle.
  always_comb begin
    alu_result = '0;
    for (int i = 0; i < 12; i++)
      if (ctrl_signal[i]) alu_result = alu_fn(i, alu_x, alu_y);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output bit ok);
    int t;
    t = 0;
    while (!req_ready && t < 50) begin
      step();
      t++;
    end
    ok = req_ready;
  endtask

  task automatic wait_done(output bit ok);
    int t;
    t = 0;
    while (!done && t < 50) begin
      step();
      t++;
    end
    ok = done;
  endtask

  task automatic run_op(input int op, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output int held);
    bit ok;
    req_op = 4'(op);
    req_x = x;
    req_y = y;
    req_valid = 1'b1;
    wait_ready(ok);
    step();
    req_valid = 1'b0;
    lat = -1;
    held = 0;
    if (ok) begin
      for (int n = 0; n < 40; n++) begin
        if (done) begin
          lat = n;
          break;
        end
        if (busy && ctrl_signal == (12'b1 << op)) held++;
        step();
      end
    end
    if (lat < 0) begin
      miscompares++;
      $display("FAIL run_op timeout: op %0d got no done", op);
    end
  endtask

  task automatic test_reset();
    clr = 1'b0;
    step();
    step();
    vectors++;
    if (req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready: got %b want 0", req_ready);
    end
    vectors++;
    if ({ctrl_signal, alu_x, alu_y, zhi, zlo, done, busy, err} !== '0) begin
      miscompares++;
      $display("FAIL reset_outs: ctrl %h x %h y %h zhi %h zlo %h d%b b%b e%b want all 0",
               ctrl_signal, alu_x, alu_y, zhi, zlo, done, busy, err);
    end
    clr = 1'b1;
    step();
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_add();
    int lat, held;
    run_op(0, 32'd5, 32'd7, lat, held);
    vectors++;
    if (lat !== SC || held !== SC) begin
      miscompares++;
      $display("FAIL add_timing: lat %0d held %0d want %0d", lat, held, SC);
    end
    vectors++;
    if (zlo !== 32'd12 || zhi !== 32'd0 || ctrl_signal !== 12'h000) begin
      miscompares++;
      $display("FAIL add_result: zhi %h zlo %h ctrl %h want 0/c/000", zhi, zlo, ctrl_signal);
    end
    step();
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL add_done_pulse: got %b want 0", done);
    end
  endtask

  task automatic test_mul();
    int lat, held;
    run_op(2, 32'h0001_0000, 32'h0001_0000, lat, held);
    vectors++;
    if (lat !== MC || held !== MC) begin
      miscompares++;
      $display("FAIL mul_timing: lat %0d held %0d want %0d", lat, held, MC);
    end
    vectors++;
    if (zhi !== 32'd1 || zlo !== 32'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mul_result: zhi %h zlo %h busy %b want 1/0/0", zhi, zlo, busy);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    req_op = 4'd1;
    req_x = 32'd9;
    req_y = 32'd4;
    req_valid = 1'b1;
    wait_ready(ok);
    step();
    req_op = 4'd9;
    req_x = 32'd3;
    req_y = 32'd8;
    vectors++;
    if (ctrl_signal !== 12'h002) begin
      miscompares++;
      $display("FAIL b2b_ctrl1: got %h want 002", ctrl_signal);
    end
    wait_done(ok);
    vectors++;
    if (!ok || zlo !== 32'd5 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_first: done %b zlo %h ready %b want 1/5/1", ok, zlo, req_ready);
    end
    step();
    req_valid = 1'b0;
    vectors++;
    if (ctrl_signal !== 12'h200 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_ctrl2: ctrl %h busy %b want 200/1", ctrl_signal, busy);
    end
    wait_done(ok);
    vectors++;
    if (!ok || zlo !== 32'd11 || zhi !== 32'd0) begin
      miscompares++;
      $display("FAIL b2b_second: done %b zhi %h zlo %h want 1/0/b", ok, zhi, zlo);
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    int dones;
    req_op = 4'd2;
    req_x = 32'h0001_0000;
    req_y = 32'h0001_0000;
    req_valid = 1'b1;
    wait_ready(ok);
    step();
    req_valid = 1'b0;
    step();
    step();
    clr = 1'b0;
    #1;
    vectors++;
    if ({ctrl_signal, alu_x, alu_y, zhi, zlo, done, busy, err, req_ready} !== '0) begin
      miscompares++;
      $display("FAIL midrst_outs: ctrl %h x %h y %h zhi %h zlo %h d%b b%b r%b want 0",
               ctrl_signal, alu_x, alu_y, zhi, zlo, done, busy, req_ready);
    end
    step();
    step();
    clr = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_ready: got %b want 1", req_ready);
    end
    dones = 0;
    for (int n = 0; n < 8; n++) begin
      step();
      if (done) dones++;
    end
    vectors++;
    if (dones !== 0 || zhi !== 32'd0) begin
      miscompares++;
      $display("FAIL midrst_nodone: dones %0d zhi %h want 0/0", dones, zhi);
    end
  endtask

  task automatic test_isolation();
    bit ok;
    int bad, n;
    logic [31:0] ax, ay, bx, by;
    logic [63:0] z;
    ax = $urandom();
    ay = $urandom();
    bx = ~ax;
    by = ay ^ 32'h5A5A_5A5A;
    req_op = 4'd2;
    req_x = ax;
    req_y = ay;
    req_valid = 1'b1;
    wait_ready(ok);
    step();
    req_valid = 1'b0;
    bad = 0;
    n = 0;
    while (!done && n < 40) begin
      if (n == 1) begin
        req_op = 4'd8;
        req_x = bx;
        req_y = by;
        req_valid = 1'b1;
      end
      if (n == 2) req_valid = 1'b0;
      if (n == 3) req_valid = 1'b1;
      if (alu_x !== ax || alu_y !== ay || ctrl_signal !== 12'h004) bad++;
      step();
      n++;
    end
    vectors++;
    if (bad !== 0 || n !== MC) begin
      miscompares++;
      $display("FAIL iso_hold: bad cycles %0d wait %0d want 0/%0d", bad, n, MC);
    end
    z = exp_z(2, ax, ay);
    vectors++;
    if ({zhi, zlo} !== z) begin
      miscompares++;
      $display("FAIL iso_mul: got %h want %h", {zhi, zlo}, z);
    end
    step();
    req_valid = 1'b0;
    vectors++;
    if (ctrl_signal !== 12'h100 || alu_x !== bx || alu_y !== by) begin
      miscompares++;
      $display("FAIL iso_accept: ctrl %h x %h y %h want 100/%h/%h",
               ctrl_signal, alu_x, alu_y, bx, by);
    end
    wait_done(ok);
    vectors++;
    if (!ok || zlo !== (bx & by) || zhi !== 32'd0) begin
      miscompares++;
      $display("FAIL iso_and: zhi %h zlo %h want 0/%h", zhi, zlo, bx & by);
    end
  endtask

  task automatic illegal_seq(input logic [3:0] op, input logic [63:0] zprev);
    bit ok;
    int errs, dones, act;
    logic err0;
    req_op = op;
    req_x = $urandom();
    req_y = $urandom();
    req_valid = 1'b1;
    wait_ready(ok);
    step();
    req_valid = 1'b0;
    err0 = err;
    errs = 0;
    dones = 0;
    act = 0;
    for (int n = 0; n < 6; n++) begin
      if (err) errs++;
      if (done) dones++;
      if (busy || ctrl_signal != 12'h000) act++;
      step();
    end
    vectors++;
    if (err0 !== TRAP || errs !== int'(TRAP)) begin
      miscompares++;
      $display("FAIL illegal_err: first %b pulses %0d want %b/%0d", err0, errs, TRAP, TRAP);
    end
    vectors++;
    if (dones !== 0 || act !== 0 || {zhi, zlo} !== zprev) begin
      miscompares++;
      $display("FAIL illegal_quiet: dones %0d act %0d z %h want 0/0/%h",
               dones, act, {zhi, zlo}, zprev);
    end
  endtask

  task automatic test_illegal();
    int lat, held;
    run_op(0, 32'd5, 32'd7, lat, held);
    step();
    illegal_seq(4'hD, 64'd12);
  endtask

  task automatic test_random();
    int op, lat, held, gap;
    logic [31:0] x, y;
    logic [63:0] z;
    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 15));
      x = $urandom();
      y = (op == 3) ? $urandom_range(0, 1000) : $urandom();
      if (op >= 12) begin
        illegal_seq(4'(op), {zhi, zlo});
      end else begin
        run_op(op, x, y, lat, held);
        z = exp_z(op, x, y);
        vectors++;
        if (lat !== exp_lat(op) || held !== exp_lat(op) || {zhi, zlo} !== z) begin
          miscompares++;
          $display("FAIL rand op%0d x %h y %h: lat %0d held %0d z %h want %0d/%h",
                   op, x, y, lat, held, {zhi, zlo}, exp_lat(op), z);
        end
      end
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) step();
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_add();
    test_mul();
    test_back_to_back();
    test_mid_reset();
    test_isolation();
    test_illegal();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
